// File: rtl/regfile_pkg.sv
// Shared constants and slice helper for the multiport register file.
package regfile_pkg;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int ZERO_REG   = 0;

  // Low bit of element idx in a flattened bus of w-bit elements.
  function automatic int sliceLo(input int idx, input int w);
    return idx * w;
  endfunction
endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, set at issue,
// cleared by writeback or flush, looked up per read port.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 2,
  parameter bit BYPASS = 1'b1
) (
  input  logic                     CLK,
  input  logic                     Reset,
  input  logic                     Flush,
  input  logic                     ResvEn,
  input  logic [ADDR_W-1:0]        ResvAddr,
  input  logic [NUM_WR-1:0]        WrEn,
  input  logic [NUM_WR*ADDR_W-1:0] WrAddr,
  input  logic [NUM_RD*ADDR_W-1:0] RdAddr,
  output logic [NUM_RD-1:0]        RdBusy
);
  localparam int NUM_REGS = 2**ADDR_W;

  logic [NUM_REGS-1:0] busy, busyNext;

  // Release first, then flush/reserve, so a same-cycle reservation wins.
  always_comb begin
    busyNext = busy;
    for (int j = 0; j < NUM_WR; j++) begin
      if (WrEn[j] && WrAddr[sliceLo(j, ADDR_W) +: ADDR_W] != ADDR_W'(ZERO_REG))
        busyNext[WrAddr[sliceLo(j, ADDR_W) +: ADDR_W]] = 1'b0;
    end
    if (Flush)
      busyNext = '0;
    else if (ResvEn && ResvAddr != ADDR_W'(ZERO_REG))
      busyNext[ResvAddr] = 1'b1;
    busyNext[ZERO_REG] = 1'b0;
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) busy <= '0;
    else        busy <= busyNext;
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : gRd
    logic [ADDR_W-1:0] addr;
    logic              fwd;
    assign addr = RdAddr[sliceLo(i, ADDR_W) +: ADDR_W];

    always_comb begin
      fwd = 1'b0;
      if (BYPASS) begin
        for (int j = 0; j < NUM_WR; j++) begin
          if (WrEn[j] && WrAddr[sliceLo(j, ADDR_W) +: ADDR_W] == addr)
            fwd = 1'b1;
        end
      end
    end

    assign RdBusy[i] = Reset && busy[addr] && !fwd;
  end
endmodule

// File: rtl/multiport_regfile.sv
// Register file with NUM_RD combinational reads, NUM_WR synchronous writes,
// optional write-to-read bypass and a pending-write scoreboard.
module multiport_regfile
  import regfile_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 2,
  parameter bit BYPASS = 1'b1
) (
  input  logic                     CLK,
  input  logic                     Reset,
  input  logic                     Flush,
  input  logic [NUM_RD*ADDR_W-1:0] RdAddr,
  output logic [NUM_RD*DATA_W-1:0] RdData,
  output logic [NUM_RD-1:0]        RdBusy,
  input  logic [NUM_WR-1:0]        WrEn,
  input  logic [NUM_WR*ADDR_W-1:0] WrAddr,
  input  logic [NUM_WR*DATA_W-1:0] WrData,
  input  logic                     ResvEn,
  input  logic [ADDR_W-1:0]        ResvAddr
);
  localparam int NUM_REGS = 2**ADDR_W;

  if (NUM_RD < 1 || NUM_RD > 4) begin : gBadRd
    $fatal(1, "multiport_regfile: NUM_RD must be 1..4");
  end
  if (NUM_WR < 1 || NUM_WR > 2) begin : gBadWr
    $fatal(1, "multiport_regfile: NUM_WR must be 1..2");
  end

  logic [NUM_REGS-1:0][DATA_W-1:0] regs;
  logic [NUM_WR-1:0][ADDR_W-1:0]   wrA;
  logic [NUM_WR-1:0][DATA_W-1:0]   wrD;
  logic [NUM_RD-1:0][DATA_W-1:0]   rdVal;

  for (genvar j = 0; j < NUM_WR; j++) begin : gWr
    assign wrA[j] = WrAddr[sliceLo(j, ADDR_W) +: ADDR_W];
    assign wrD[j] = WrData[sliceLo(j, DATA_W) +: DATA_W];
  end

  // Ports applied in ascending order so the highest index wins a conflict.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      regs <= '0;
    end else begin
      for (int j = 0; j < NUM_WR; j++) begin
        if (WrEn[j] && wrA[j] != ADDR_W'(ZERO_REG))
          regs[wrA[j]] <= wrD[j];
      end
    end
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : gRd
    logic [ADDR_W-1:0] addr;
    assign addr = RdAddr[sliceLo(i, ADDR_W) +: ADDR_W];

    always_comb begin
      rdVal[i] = regs[addr];
      if (BYPASS) begin
        for (int j = 0; j < NUM_WR; j++) begin
          if (WrEn[j] && wrA[j] == addr)
            rdVal[i] = wrD[j];
        end
      end
      // Forwarded data must not leak out while held in reset.
      if (!Reset || addr == ADDR_W'(ZERO_REG))
        rdVal[i] = '0;
    end
  end

  assign RdData = rdVal;

  regfile_scoreboard #(
    .ADDR_W(ADDR_W),
    .NUM_RD(NUM_RD),
    .NUM_WR(NUM_WR),
    .BYPASS(BYPASS)
  ) uScoreboard (
    .CLK     (CLK),
    .Reset   (Reset),
    .Flush   (Flush),
    .ResvEn  (ResvEn),
    .ResvAddr(ResvAddr),
    .WrEn    (WrEn),
    .WrAddr  (WrAddr),
    .RdAddr  (RdAddr),
    .RdBusy  (RdBusy)
  );
endmodule

// File: tb/tb_multiport_regfile.sv
// Directed bench: a bypassing and a non-bypassing regfile share one stimulus.
module tb_multiport_regfile;
  logic        CLK = 1'b0;
  logic        Reset;
  logic        Flush;
  logic [9:0]  RdAddr;
  logic [63:0] RdData, RdDataNb;
  logic [1:0]  RdBusy, RdBusyNb;
  logic [1:0]  WrEn;
  logic [9:0]  WrAddr;
  logic [63:0] WrData;
  logic        ResvEn;
  logic [4:0]  ResvAddr;

  int nChecks = 0;
  int nErr    = 0;

  always #5 CLK = ~CLK;

  multiport_regfile #(.BYPASS(1'b1)) dut (
    .CLK(CLK), .Reset(Reset), .Flush(Flush),
    .RdAddr(RdAddr), .RdData(RdData), .RdBusy(RdBusy),
    .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData),
    .ResvEn(ResvEn), .ResvAddr(ResvAddr)
  );

  multiport_regfile #(.BYPASS(1'b0)) dutNb (
    .CLK(CLK), .Reset(Reset), .Flush(Flush),
    .RdAddr(RdAddr), .RdData(RdDataNb), .RdBusy(RdBusyNb),
    .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData),
    .ResvEn(ResvEn), .ResvAddr(ResvAddr)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nErr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    WrEn = '0; ResvEn = 1'b0; Flush = 1'b0;
  endtask

  task automatic wr(input int p, input logic [4:0] a, input logic [31:0] d);
    WrEn[p] = 1'b1;
    WrAddr[p*5 +: 5]  = a;
    WrData[p*32 +: 32] = d;
  endtask

  task automatic rd(input logic [4:0] a0, input logic [4:0] a1);
    RdAddr = {a1, a0};
    #1;
  endtask

  initial begin
    Reset = 1'b0; Flush = 1'b0; RdAddr = '0; WrEn = '0; WrAddr = '0;
    WrData = '0; ResvEn = 1'b0; ResvAddr = '0;
    rd(5'd5, 5'd3);
    chk("rst_rd0", RdData[31:0], 32'h0);
    chk("rst_busy", {30'b0, RdBusy}, 32'h0);
    step();
    Reset = 1'b1;

    // Write + reserve r5, then reset asynchronously mid-operation
    wr(0, 5'd5, 32'h1234); ResvEn = 1'b1; ResvAddr = 5'd5;
    step(); idle();
    rd(5'd5, 5'd5);
    chk("r5_written", RdData[31:0], 32'h1234);
    chk("r5_busy", {31'b0, RdBusy[0]}, 32'h1);
    Reset = 1'b0; #1;
    chk("rst_mid_rd0", RdData[31:0], 32'h0);
    chk("rst_mid_rd1", RdData[63:32], 32'h0);
    chk("rst_mid_busy", {30'b0, RdBusy}, 32'h0);
    step();
    Reset = 1'b1; #1;
    chk("r5_after_rst", RdData[31:0], 32'h0);
    chk("r5_busy_after_rst", {31'b0, RdBusy[0]}, 32'h0);

    // Same-cycle write conflict on r3: port1 wins
    wr(0, 5'd3, 32'hDEADBEEF); wr(1, 5'd3, 32'h0BADF00D);
    rd(5'd3, 5'd3);
    chk("conflict_bypass", RdData[31:0], 32'h0BADF00D);
    chk("conflict_nb_old", RdDataNb[31:0], 32'h0);
    step(); idle(); #1;
    chk("conflict_stored", RdData[31:0], 32'h0BADF00D);
    chk("conflict_nb_stored", RdDataNb[63:32], 32'h0BADF00D);

    // r0 ignores writes and reservations
    wr(0, 5'd0, 32'hFFFFFFFF); ResvEn = 1'b1; ResvAddr = 5'd0;
    rd(5'd0, 5'd0);
    chk("r0_bypass_rd0", RdData[31:0], 32'h0);
    chk("r0_bypass_rd1", RdData[63:32], 32'h0);
    step(); idle(); #1;
    chk("r0_rd0", RdData[31:0], 32'h0);
    chk("r0_rd1", RdData[63:32], 32'h0);
    chk("r0_busy", {30'b0, RdBusy}, 32'h0);

    // Reserve r7, then writeback releases it
    ResvEn = 1'b1; ResvAddr = 5'd7;
    rd(5'd7, 5'd7);
    chk("r7_busy_same_cycle", {31'b0, RdBusy[0]}, 32'h0);
    step(); idle(); #1;
    chk("r7_busy", {31'b0, RdBusy[0]}, 32'h1);
    wr(1, 5'd7, 32'h55); #1;
    chk("r7_bypass", RdData[31:0], 32'h55);
    chk("r7_bypass_busy", {31'b0, RdBusy[0]}, 32'h0);
    chk("r7_nb_busy", {31'b0, RdBusyNb[1]}, 32'h1);
    step(); idle(); #1;
    chk("r7_released", {31'b0, RdBusy[1]}, 32'h0);
    chk("r7_data", RdData[63:32], 32'h55);

    // Reserve beats write on the same register; flush beats reserve
    ResvEn = 1'b1; ResvAddr = 5'd9; wr(0, 5'd9, 32'h77);
    step(); idle();
    rd(5'd9, 5'd10);
    chk("r9_data", RdData[31:0], 32'h77);
    chk("r9_busy", {31'b0, RdBusy[0]}, 32'h1);
    Flush = 1'b1; ResvEn = 1'b1; ResvAddr = 5'd10;
    step(); idle(); #1;
    chk("flush_busy", {30'b0, RdBusy}, 32'h0);
    chk("flush_data", RdData[31:0], 32'h77);

    // Non-bypassing build sees a write only after the edge
    wr(1, 5'd4, 32'hA5A5A5A5);
    rd(5'd3, 5'd4);
    chk("nb_same_cycle", RdDataNb[63:32], 32'h0);
    chk("byp_same_cycle", RdData[63:32], 32'hA5A5A5A5);
    step(); idle(); #1;
    chk("nb_next_cycle", RdDataNb[63:32], 32'hA5A5A5A5);
    chk("nb_r3", RdDataNb[31:0], 32'h0BADF00D);

    $display("Result: errors=%0d of %0d checks", nErr, nChecks);
    $finish;
  end
endmodule
